// File: rtl/core_dmem_axi_if.sv
// AXI4-Lite bus bundle between the memory-stage master (core_dmem_axi) and the data memory.
interface core_dmem_axi_if;
  logic [31:0] M_AWADDR;
  logic        M_AWVALID;
  logic        M_AWREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WVALID;
  logic        M_WREADY;
  logic        M_BVALID;
  logic [1:0]  M_BRESP;
  logic        M_BREADY;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RVALID;
  logic        M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
           M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

  modport slave (
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
           M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );
endinterface

// File: rtl/core_dmem_axi.sv
// Memory-stage AXI4-Lite master: one single-beat load or store per request, DONE pulse on completion.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned H/W requests complete immediately with ERR and no bus traffic.
module core_dmem_axi #(
  parameter int TMO_W = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  C_LOAD,
  input  logic                  C_STORE,
  input  logic [31:0]           DMEM_ARADDR,
  input  logic [3:0]            STRB,
  input  logic [2:0]            FUNCT3,
  input  logic [31:0]           REG_RDATA2,
  output logic [31:0]           LOAD_DATA,
  output logic                  DMEM_DONE,
  output logic                  DMEM_BUSY,
  output logic                  DMEM_ERR,
  core_dmem_axi_if.master       m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  // Abort fires on the cycle the counter would reach all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic [2:0]       f3_q, f3_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             err_q, err_d;
  logic [31:0]      ld_q, ld_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             aw_hs, w_hs, tmo_hit;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] d;
    d = rdata >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   return {{24{~f3[2] & d[7]}}, d[7:0]};
      2'b01:   return {{16{~f3[2] & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] off, input logic [2:0] f3);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      f3_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      f3_q      <= f3_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      ld_q      <= ld_d;
      tmo_q     <= tmo_d;
    end
  end

  assign aw_hs   = m_axi.M_AWVALID & m_axi.M_AWREADY;
  assign w_hs    = m_axi.M_WVALID & m_axi.M_WREADY;
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    f3_d      = f3_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    ld_d      = ld_q;
    tmo_d     = tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (C_STORE || C_LOAD) begin
          addr_d    = DMEM_ARADDR;
          wdata_d   = REG_RDATA2 << {DMEM_ARADDR[1:0], 3'b000};
          strb_d    = STRB;
          f3_d      = FUNCT3;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = C_STORE ? S_WR : S_AR;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (misaligned(DMEM_ARADDR[1:0], FUNCT3)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (!C_STORE) ld_d = '0;
          end
`endif
        end
      end
      S_WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W may finish in either order; move on only once both have.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_B;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_B: begin
        if (m_axi.M_BVALID) begin
          state_d = S_DONE;
          err_d   = (m_axi.M_BRESP != 2'b00);
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_AR: begin
        if (m_axi.M_ARREADY) begin
          state_d = S_R;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_R: begin
        if (m_axi.M_RVALID) begin
          state_d = S_DONE;
          err_d   = (m_axi.M_RRESP != 2'b00);
          ld_d    = (m_axi.M_RRESP != 2'b00) ? '0
                  : load_extend(m_axi.M_RDATA, addr_q[1:0], f3_q);
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ld_d    = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) tmo_d = '0;
  end

  assign m_axi.M_AWADDR  = {addr_q[31:2], 2'b00};
  assign m_axi.M_ARADDR  = {addr_q[31:2], 2'b00};
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = strb_q;
  assign m_axi.M_AWVALID = (state_q == S_WR) && !aw_done_q;
  assign m_axi.M_WVALID  = (state_q == S_WR) && !w_done_q;
  assign m_axi.M_BREADY  = (state_q == S_B);
  assign m_axi.M_ARVALID = (state_q == S_AR);
  assign m_axi.M_RREADY  = (state_q == S_R);

  assign DMEM_DONE = (state_q == S_DONE);
  assign DMEM_ERR  = (state_q == S_DONE) && err_q;
  assign DMEM_BUSY = (state_q == S_WR) || (state_q == S_B) ||
                     (state_q == S_AR) || (state_q == S_R);
  assign LOAD_DATA = ld_q;

endmodule

// File: tb/tb_core_dmem_axi.sv
// Randomized self-checking bench for core_dmem_axi against a transaction-level reference model.
module tb_core_dmem_axi;

  localparam int TMO = 1023;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        C_LOAD = 1'b0;
  logic        C_STORE = 1'b0;
  logic [31:0] DMEM_ARADDR = '0;
  logic [3:0]  STRB = '0;
  logic [2:0]  FUNCT3 = '0;
  logic [31:0] REG_RDATA2 = '0;
  logic [31:0] LOAD_DATA;
  logic        DMEM_DONE, DMEM_BUSY, DMEM_ERR;

  int n_checks = 0;
  int n_errors = 0;

  core_dmem_axi_if bus ();

  core_dmem_axi #(.TMO_W(10)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .C_LOAD      (C_LOAD),
    .C_STORE     (C_STORE),
    .DMEM_ARADDR (DMEM_ARADDR),
    .STRB        (STRB),
    .FUNCT3      (FUNCT3),
    .REG_RDATA2  (REG_RDATA2),
    .LOAD_DATA   (LOAD_DATA),
    .DMEM_DONE   (DMEM_DONE),
    .DMEM_BUSY   (DMEM_BUSY),
    .DMEM_ERR    (DMEM_ERR),
    .m_axi       (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic slave_idle();
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.M_BVALID  = 1'b0;
    bus.M_BRESP   = 2'b00;
    bus.M_ARREADY = 1'b0;
    bus.M_RVALID  = 1'b0;
    bus.M_RDATA   = '0;
    bus.M_RRESP   = 2'b00;
  endtask

  function automatic bit is_trap(input logic [31:0] a, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_TRAP_EN
    return ((f3[1:0] == 2'b01) && (a[0] == 1'b1)) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // Reference load result: pick the addressed bytes, then sign/zero-extend numerically.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] rd,
                                           input logic [2:0] f3);
    longint d, v;
    d = longint'(rd) / (longint'(1) << (8 * int'(a[1:0])));
    if (f3[1:0] == 2'b00) begin
      v = d % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'b01) begin
      v = d % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return 32'(v);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] f3, input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] bresp, input bit both, input bit noise);
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_k = -1;
    int mx, wr_cyc, b_cyc, exp_k;
    bit trap, wr_to, b_to, exp_err;
    logic [31:0] exp_wdata;
    trap      = is_trap(addr, f3);
    exp_wdata = data << (8 * int'(addr[1:0]));
    mx        = (aw_dly > w_dly) ? aw_dly : w_dly;
    wr_to     = (mx >= TMO);
    wr_cyc    = wr_to ? TMO : mx + 1;
    b_to      = (b_dly >= TMO);
    b_cyc     = b_to ? TMO : b_dly + 1;
    exp_k     = trap ? 1 : (wr_to ? 1 + wr_cyc : 1 + wr_cyc + b_cyc);
    exp_err   = trap || wr_to || b_to || (bresp != 2'b00);
    DMEM_ARADDR = addr;
    STRB        = strb;
    FUNCT3      = f3;
    REG_RDATA2  = data;
    C_STORE     = 1'b1;
    C_LOAD      = both;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      C_STORE     = noise ? 1'($urandom) : 1'b0;
      C_LOAD      = noise ? 1'($urandom) : 1'b0;
      DMEM_ARADDR = $urandom;
      REG_RDATA2  = $urandom;
      STRB        = 4'($urandom);
      FUNCT3      = 3'($urandom);
      if (bus.M_AWVALID) begin
        if (aw_cnt == 0) chk("st_awaddr", bus.M_AWADDR, {addr[31:2], 2'b00});
        bus.M_AWREADY = (aw_cnt >= aw_dly);
        aw_cnt++;
      end else begin
        bus.M_AWREADY = 1'b0;
      end
      if (bus.M_WVALID) begin
        if (w_cnt == 0) begin
          chk("st_wdata", bus.M_WDATA, exp_wdata);
          chk("st_wstrb", bus.M_WSTRB, strb);
        end
        bus.M_WREADY = (w_cnt >= w_dly);
        w_cnt++;
      end else begin
        bus.M_WREADY = 1'b0;
      end
      if (bus.M_BREADY) begin
        bus.M_BVALID = (b_cnt >= b_dly);
        bus.M_BRESP  = bus.M_BVALID ? bresp : 2'($urandom);
        b_cnt++;
      end else begin
        bus.M_BVALID = 1'b0;
      end
      chk("st_no_read", {bus.M_ARVALID, bus.M_RREADY}, 0);
      if (DMEM_DONE) begin
        done_k  = k;
        chk("st_err", DMEM_ERR, exp_err);
        chk("st_busy_done", DMEM_BUSY, 0);
        C_STORE = 1'b0;
        C_LOAD  = 1'b0;
        break;
      end
      chk("st_busy", DMEM_BUSY, 1);
    end
    C_STORE = 1'b0;
    C_LOAD  = 1'b0;
    slave_idle();
    chk("st_done_cycle", done_k, exp_k);
    chk("st_aw_cycles", aw_cnt, trap ? 0 : imin(aw_dly + 1, TMO));
    chk("st_w_cycles", w_cnt, trap ? 0 : imin(w_dly + 1, TMO));
    tick();
    chk("st_done_pulse", DMEM_DONE, 0);
    chk("st_idle_busy", DMEM_BUSY, 0);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [31:0] rdata, input logic [2:0] f3,
                          input int ar_dly, input int r_dly, input logic [1:0] rresp, input bit noise);
    int ar_cnt = 0, r_cnt = 0, done_k = -1, exp_k;
    bit trap, exp_err;
    logic [31:0] exp_ld;
    trap    = is_trap(addr, f3);
    exp_k   = trap ? 1 : ar_dly + r_dly + 3;
    exp_err = trap || (rresp != 2'b00);
    exp_ld  = exp_err ? 32'h0 : ref_load(addr, rdata, f3);
    DMEM_ARADDR = addr;
    STRB        = 4'($urandom);
    FUNCT3      = f3;
    REG_RDATA2  = $urandom;
    C_LOAD      = 1'b1;
    C_STORE     = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      C_STORE     = noise ? 1'($urandom) : 1'b0;
      C_LOAD      = noise ? 1'($urandom) : 1'b0;
      DMEM_ARADDR = $urandom;
      FUNCT3      = 3'($urandom);
      if (bus.M_ARVALID) begin
        if (ar_cnt == 0) chk("ld_araddr", bus.M_ARADDR, {addr[31:2], 2'b00});
        bus.M_ARREADY = (ar_cnt >= ar_dly);
        ar_cnt++;
      end else begin
        bus.M_ARREADY = 1'b0;
      end
      if (bus.M_RREADY) begin
        bus.M_RVALID = (r_cnt >= r_dly);
        bus.M_RDATA  = bus.M_RVALID ? rdata : $urandom;
        bus.M_RRESP  = bus.M_RVALID ? rresp : 2'($urandom);
        r_cnt++;
      end else begin
        bus.M_RVALID = 1'b0;
      end
      chk("ld_no_write", {bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY}, 0);
      if (DMEM_DONE) begin
        done_k  = k;
        chk("ld_err", DMEM_ERR, exp_err);
        chk("ld_data", LOAD_DATA, exp_ld);
        C_STORE = 1'b0;
        C_LOAD  = 1'b0;
        break;
      end
      chk("ld_busy", DMEM_BUSY, 1);
    end
    C_STORE = 1'b0;
    C_LOAD  = 1'b0;
    slave_idle();
    chk("ld_done_cycle", done_k, exp_k);
    chk("ld_ar_cycles", ar_cnt, trap ? 0 : ar_dly + 1);
    tick();
    chk("ld_done_pulse", DMEM_DONE, 0);
    chk("ld_idle_busy", DMEM_BUSY, 0);
    chk("ld_data_held", LOAD_DATA, exp_ld);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valids"}, {bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY, bus.M_ARVALID, bus.M_RREADY}, 0);
    chk({tag, "_status"}, {DMEM_DONE, DMEM_BUSY, DMEM_ERR}, 0);
    chk({tag, "_awaddr"}, bus.M_AWADDR, 0);
    chk({tag, "_wdata"}, bus.M_WDATA, 0);
    chk({tag, "_wstrb"}, bus.M_WSTRB, 0);
    chk({tag, "_load_data"}, LOAD_DATA, 0);
  endtask

  initial begin
    slave_idle();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Directed cases
    run_store(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 3'b010, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    run_store(32'h0000_0203, 32'h0000_00A5, 4'b1000, 3'b000, 4, 0, 0, 2'b00, 1'b0, 1'b0);
    run_load(32'h0000_0101, 32'h0000_8000, 3'b000, 0, 0, 2'b00, 1'b0);
    run_load(32'h0000_0101, 32'h0000_8000, 3'b100, 0, 0, 2'b00, 1'b0);
    run_load(32'h0000_0102, 32'h8001_0000, 3'b001, 0, 7, 2'b00, 1'b1);
    run_load(32'h0000_0200, 32'h1234_5678, 3'b010, 0, 0, 2'b10, 1'b0);
    run_store(32'h0000_0300, 32'h0BAD_F00D, 4'b0000, 3'b010, 0, 0, 2, 2'b11, 1'b0, 1'b0);
    run_store(32'h0000_0304, 32'h1111_2222, 4'b1111, 3'b010, 1, 3, 0, 2'b00, 1'b1, 1'b0);
    run_store(32'h0000_0408, 32'h5555_AAAA, 4'b1111, 3'b010, 5000, 0, 0, 2'b00, 1'b0, 1'b0);
    run_load(32'h0000_0102, 32'hCAFE_0000, 3'b010, 1, 1, 2'b00, 1'b0);

    // Reset while waiting for the write response
    DMEM_ARADDR = 32'h0000_0040;
    REG_RDATA2  = 32'h7777_8888;
    STRB        = 4'b1111;
    FUNCT3      = 3'b010;
    C_STORE     = 1'b1;
    tick();
    C_STORE       = 1'b0;
    bus.M_AWREADY = 1'b1;
    bus.M_WREADY  = 1'b1;
    tick();
    slave_idle();
    chk("rst_in_b_bready", bus.M_BREADY, 1);
    #2;
    RST = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    RST = 1'b0;
    tick();
    chk_all_zero("rst_release");
    run_store(32'h0000_0044, 32'h0102_0304, 4'b1111, 3'b010, 0, 0, 0, 2'b00, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a, d;
      logic [2:0]  f3;
      logic [1:0]  resp;
      a    = $urandom;
      d    = $urandom;
      f3   = {1'($urandom), 2'($urandom_range(0, 2))};
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        run_store(a, d, 4'($urandom), f3, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), resp, 1'($urandom), 1'($urandom));
      else
        run_load(a, d, f3, $urandom_range(0, 3), $urandom_range(0, 4), resp, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
